// File: rtl/pulse_timer_ctrl.sv
// pulse_timer_ctrl
//   Programmable tick generator with a small control FSM. Configuration
//   (divisor, tick count, periodic flag) is loaded through a valid/ready
//   handshake. The block is then started and stopped. While running, it
//   emits a one-cycle tick every div_eff cycles and counts ticks down.
//   On the last tick of a period it pulses done and sets a sticky irq.
//   A one-shot run then returns to ARMED. A periodic run reloads and keeps
//   going.
//
//   Ports
//     clk          clock, all state on rising edge
//     rst          asynchronous active-low reset
//     cfg_valid    configuration request
//     cfg_ready    high in IDLE and ARMED (configuration accepted)
//     cfg_div      prescale divisor, 0 behaves as 1
//     cfg_count    ticks per period, 0 behaves as 1
//     cfg_periodic 1 = reload and keep running after the final tick
//     start        begin (ARMED) or resume (PAUSE) counting
//     stop         pause counting while in RUN
//     irq_clear    clear sticky irq
//     tick         1-cycle pulse every div_eff cycles in RUN
//     done         1-cycle pulse together with the final tick of a period
//     irq          sticky, set together with done
//     busy         high in RUN or PAUSE
//     remaining    ticks left in the current period
module pulse_timer_ctrl #(
    parameter int Width    = 8,
    parameter int CntWidth = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [Width-1:0]    cfg_div,
    input  logic [CntWidth-1:0] cfg_count,
    input  logic                cfg_periodic,
    input  logic                start,
    input  logic                stop,
    input  logic                irq_clear,
    output logic                tick,
    output logic                done,
    output logic                irq,
    output logic                busy,
    output logic [CntWidth-1:0] remaining
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, PAUSE} state_t;

    localparam logic [Width-1:0]    DivOne = Width'(1);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    // A zero divisor or zero count is treated as one.
    function automatic logic [Width-1:0] clamp_div(input logic [Width-1:0] d);
        return (d == '0) ? DivOne : d;
    endfunction

    function automatic logic [CntWidth-1:0] clamp_cnt(input logic [CntWidth-1:0] c);
        return (c == '0) ? CntOne : c;
    endfunction

    state_t              state;
    logic [Width-1:0]    div_eff;
    logic [CntWidth-1:0] cnt_eff;
    logic                periodic;
    logic [Width-1:0]    prescaler;
    logic [Width-1:0]    div_last;
    logic                cfg_accept;

    assign cfg_ready  = (state == IDLE) || (state == ARMED);
    assign busy       = (state == RUN) || (state == PAUSE);
    assign cfg_accept = cfg_valid && cfg_ready;
    // div_eff is never 0 outside IDLE, so this subtraction cannot wrap while
    // the prescaler is actually running.
    assign div_last   = div_eff - DivOne;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            div_eff   <= '0;
            cnt_eff   <= '0;
            periodic  <= 1'b0;
            prescaler <= '0;
            remaining <= '0;
            tick      <= 1'b0;
            done      <= 1'b0;
            irq       <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            // A set later in this block overrides the clear.
            if (irq_clear) begin
                irq <= 1'b0;
            end

            if (cfg_accept) begin
                div_eff   <= clamp_div(cfg_div);
                cnt_eff   <= clamp_cnt(cfg_count);
                periodic  <= cfg_periodic;
                remaining <= clamp_cnt(cfg_count);
            end

            case (state)
                IDLE: begin
                    if (cfg_accept) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    // A configuration write takes precedence over start.
                    if (!cfg_accept && start) begin
                        state     <= RUN;
                        prescaler <= '0;
                    end
                end
                RUN: begin
                    // stop freezes everything, including a tick due this edge.
                    if (stop) begin
                        state <= PAUSE;
                    end else if (prescaler == div_last) begin
                        prescaler <= '0;
                        tick      <= 1'b1;
                        if (remaining == CntOne) begin
                            done      <= 1'b1;
                            irq       <= 1'b1;
                            remaining <= cnt_eff;
                            if (!periodic) begin
                                state <= ARMED;
                            end
                        end else begin
                            remaining <= remaining - CntOne;
                        end
                    end else begin
                        prescaler <= prescaler + DivOne;
                    end
                end
                PAUSE: begin
                    // The prescaler resumes from its frozen value.
                    if (start && !stop) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
